nibble_deserializer: RTL and testbench

//  Serial-to-parallel front end for the 4-input parity/XNOR gate stage.

---
 rtl/nibble_deserializer_pkg.sv | 22 ++
 rtl/nibble_deserializer_if.sv | 23 ++
 rtl/nibble_deserializer_idle_timer.sv | 22 ++
 rtl/nibble_deserializer.sv | 113 +++++++++++
 tb/tb_nibble_deserializer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_deserializer_pkg.sv
// Shared definitions for the nibble deserializer: state encodings and frame length.
// Frame length depends on NIBBLE_PARITY_EN (5-bit frames with a trailing even-parity bit).
package nibble_deserializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

`ifdef NIBBLE_PARITY_EN
  localparam int FRAME_BITS = 5;
`else
  localparam int FRAME_BITS = 4;
`endif

  localparam int CNT_W = 3;

  // An odd number of ones over the whole frame means even parity was violated
  function automatic logic parity_odd(input logic [FRAME_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/nibble_deserializer_if.sv
// Serial-in / nibble-out bus of the deserializer.
// master = upstream/downstream side, slave = the deserializer itself.
interface nibble_deserializer_if;
  logic sin;
  logic sin_valid;
  logic out_ready;
  logic clr_ovr;
  logic a, b, c, d;
  logic out_valid;
  logic overrun;
  logic timeout;
  logic par_err;

  modport master (
    output sin, sin_valid, out_ready, clr_ovr,
    input  a, b, c, d, out_valid, overrun, timeout, par_err
  );

  modport slave (
    input  sin, sin_valid, out_ready, clr_ovr,
    output a, b, c, d, out_valid, overrun, timeout, par_err
  );
endinterface

// File: rtl/nibble_deserializer_idle_timer.sv
// Saturating idle counter; expired flags the run cycle that brings the count to TIMEOUT.
module nib_idle_timer #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)                       r_cnt <= '0;
    else if (run && r_cnt != TO_W'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
  end

  assign expired = run && (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/nibble_deserializer.sv
// MSB-first serial-to-nibble deserializer with valid/ready hold, overrun and idle timeout.
// Build option: NIBBLE_PARITY_EN adds a trailing even-parity bit per frame and drives par_err.
module nibble_deserializer
  import nibble_deserializer_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input logic                  clk,
  input logic                  rst,
  nibble_deserializer_if.slave bus
);

  logic [1:0]            r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_overrun;
  logic                  r_timeout;

  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic                  w_last;
  logic                  w_drop;
  logic                  w_expired;
  logic                  w_timer_clr;
  logic                  w_timer_run;

  assign w_shift_nxt = {r_shift[FRAME_BITS-2:0], bus.sin};
  assign w_last      = (r_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_drop      = (r_state == ST_HOLD) && bus.sin_valid && !bus.out_ready;
  assign w_timer_run = (r_state == ST_SHIFT) && !bus.sin_valid;
  assign w_timer_clr = (r_state != ST_SHIFT) || bus.sin_valid;

  nib_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clr),
    .run     (w_timer_run),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.sin_valid) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.sin_valid) begin
            r_shift <= w_shift_nxt;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_expired) begin
            // Abort keeps the partial bits on a..d; only the frame state is dropped
            r_timeout <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            if (bus.sin_valid) begin
              r_shift <= w_shift_nxt;
              r_cnt   <= CNT_W'(1);
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A new drop outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)              r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (bus.clr_ovr) r_overrun <= 1'b0;
  end

  assign {bus.a, bus.b, bus.c, bus.d} = r_shift[FRAME_BITS-1 -: 4];
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.overrun   = r_overrun;
  assign bus.timeout   = r_timeout;

`ifdef NIBBLE_PARITY_EN
  assign bus.par_err = bus.out_valid && parity_odd(r_shift);
`else
  assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_deserializer.sv
// Self-checking bench: frame-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with bursty idle gaps.
module tb_nibble_deserializer;
  import nibble_deserializer_pkg::*;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_deserializer_if bus();

  nibble_deserializer #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits collected so far, whether a frame is held, idle run length
  bit                    m_en   = 0;
  bit                    m_held = 0;
  int                    m_len  = 0;
  int                    m_idle = 0;
  logic [FRAME_BITS-1:0] m_sr   = '0;
  bit                    m_ovr  = 0;
  bit                    m_to   = 0;
  bit                    m_drop;

  always @(posedge clk) begin
    m_to = 0;
    if (rst) begin
      m_en = 1; m_held = 0; m_len = 0; m_idle = 0; m_sr = '0; m_ovr = 0;
    end else begin
      m_drop = m_held && bus.sin_valid && !bus.out_ready;
      if (m_held) begin
        if (bus.out_ready) begin
          m_held = 0;
          if (bus.sin_valid) begin
            m_sr = {m_sr[FRAME_BITS-2:0], bus.sin};
            m_len = 1;
            m_idle = 0;
          end
        end
      end else if (bus.sin_valid) begin
        m_sr = {m_sr[FRAME_BITS-2:0], bus.sin};
        m_len++;
        m_idle = 0;
        if (m_len == FRAME_BITS) begin
          m_held = 1;
          m_len = 0;
        end
      end else if (m_len > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_to = 1; m_len = 0; m_idle = 0;
        end
      end
      if (m_drop)            m_ovr = 1;
      else if (bus.clr_ovr)  m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk1("out_valid", bus.out_valid, m_held);
      chk4("abcd", {bus.a, bus.b, bus.c, bus.d}, m_sr[FRAME_BITS-1 -: 4]);
      chk1("overrun", bus.overrun, m_ovr);
      chk1("timeout", bus.timeout, m_to);
`ifdef NIBBLE_PARITY_EN
      chk1("par_err", bus.par_err, m_held && (^m_sr));
`else
      chk1("par_err", bus.par_err, 1'b0);
`endif
    end
  end

  task automatic step(input logic sv, input logic s, input logic rdy,
                      input logic clr, input logic r = 1'b0);
    bus.sin_valid = sv;
    bus.sin       = s;
    bus.out_ready = rdy;
    bus.clr_ovr   = clr;
    rst           = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [FRAME_BITS-1:0] bits);
    for (int i = FRAME_BITS - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
  endtask

  function automatic logic [3:0] nib();
    return {bus.a, bus.b, bus.c, bus.d};
  endfunction

  initial begin
    bus.sin = 0; bus.sin_valid = 0; bus.out_ready = 0; bus.clr_ovr = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk1("rst_valid", bus.out_valid, 1'b0);
    chk4("rst_abcd", nib(), 4'b0000);
    chk1("rst_overrun", bus.overrun, 1'b0);
    chk1("rst_timeout", bus.timeout, 1'b0);
    chk1("rst_par_err", bus.par_err, 1'b0);

`ifdef NIBBLE_PARITY_EN
    send(5'b10110);
    chk1("p1_valid", bus.out_valid, 1'b1);
    chk1("p1_par_err", bus.par_err, 1'b1);
    step(0, 0, 1, 0);
    chk1("p1_par_clr", bus.par_err, 1'b0);
    send(5'b10111);
    chk1("p2_par_err", bus.par_err, 1'b0);
    chk4("p2_abcd", nib(), 4'b1011);
    step(0, 0, 1, 0);
`else
    // Basic frame and hold
    send(4'b1011);
    chk1("t1_valid", bus.out_valid, 1'b1);
    chk4("t1_abcd", nib(), 4'b1011);
    repeat (10) step(0, 0, 0, 0);
    chk1("t1_hold_valid", bus.out_valid, 1'b1);
    chk4("t1_hold_abcd", nib(), 4'b1011);
    chk1("t1_overrun", bus.overrun, 1'b0);

    // Handshake and first bit of next frame in the same cycle
    step(1, 1, 1, 0);
    chk1("t2_drop_valid", bus.out_valid, 1'b0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk1("t2_valid", bus.out_valid, 1'b1);
    chk4("t2_abcd", nib(), 4'b1000);
    chk1("t2_overrun", bus.overrun, 1'b0);
    step(0, 0, 1, 0);

    // Idle abort of a partial frame
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    repeat (14) step(0, 0, 0, 0);
    chk1("t3_no_early_to", bus.timeout, 1'b0);
    step(0, 0, 0, 0);
    chk1("t3_timeout", bus.timeout, 1'b1);
    chk1("t3_valid", bus.out_valid, 1'b0);
    step(0, 0, 0, 0);
    chk1("t3_pulse_end", bus.timeout, 1'b0);
    send(4'b0101);
    chk4("t3_abcd", nib(), 4'b0101);
    chk1("t3_valid2", bus.out_valid, 1'b1);
    step(0, 0, 1, 0);

    // Drops while holding
    send(4'b1100);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    chk1("t4_overrun", bus.overrun, 1'b1);
    chk4("t4_abcd", nib(), 4'b1100);
    chk1("t4_valid", bus.out_valid, 1'b1);
    step(0, 0, 0, 1);
    chk1("t4_clr", bus.overrun, 1'b0);
    step(0, 0, 1, 0);

    // Reset mid-frame
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk1("t5_valid", bus.out_valid, 1'b0);
    chk4("t5_abcd", nib(), 4'b0000);
    chk1("t5_timeout", bus.timeout, 1'b0);
    send(4'b0110);
    chk4("t5_abcd2", nib(), 4'b0110);
    chk1("t5_valid2", bus.out_valid, 1'b1);
    step(0, 0, 1, 0);
`endif

    // Random traffic: each segment picks a bit density so timeouts and overruns both occur
    for (int seg = 0; seg < 60; seg++) begin
      int p;
      case ($urandom_range(2))
        0:       p = 5;
        1:       p = 60;
        default: p = 95;
      endcase
      repeat (50)
        step(($urandom_range(99) < p), $urandom_range(1),
             ($urandom_range(99) < 25), ($urandom_range(99) < 5),
             ($urandom_range(199) == 0));
    end
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
